// File: rtl/pipe_queue.sv
// Purpose: circular-buffer decoupling queue between two pipeline stages, with flush and occupancy count.
// Latency: 1 cycle from an accepted push into an empty queue to out_valid/out_data; outputs come only from registers.
// Backpressure: in_ready is low only while full (state-only, ignores out_ready); out_data holds stable while out_ready is low.
module pipe_queue #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wp_q, wp_d;
    logic [PTR_W-1:0]  rp_q, rp_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push;
    logic              pop;
    logic [PTR_W-1:0]  ptr_diff;

    // Handshake and output view, derived purely from registered state.
    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign out_data  = out_valid ? mem_q[rp_q] : '0;
    assign count     = count_q;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign ptr_diff  = wp_q - rp_q;

    // Next-state: flush wins over everything, otherwise push/pop update pointers and count.
    always_comb begin
        mem_d   = mem_q;
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        if (flush) begin
            wp_d    = '0;
            rp_d    = '0;
            count_d = '0;
        end else begin
            if (push) begin
                mem_d[wp_q] = in_data;
                wp_d        = wp_q + PTR_W'(1);
            end
            if (pop) begin
                rp_d = rp_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers; reset clears storage too so out_data is deterministic.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Occupancy never exceeds DEPTH.
    a_count_max: assert property (@(posedge clk) disable iff (!reset)
        count_q <= CNT_W'(DEPTH));

    // Pointer distance agrees with count; a full queue has coincident pointers.
    a_ptr_count: assert property (@(posedge clk) disable iff (!reset)
        (count_q == CNT_W'(DEPTH)) ? (wp_q == rp_q) : (count_q == CNT_W'(ptr_diff)));

endmodule

// File: tb/tb_pipe_queue.sv
module tb_pipe_queue;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  count;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: the queue contents, oldest first.
    logic [DATA_W-1:0] mq [$];

    pipe_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, clock it, advance the model, settle 1 time unit past the edge.
    task automatic tick(input logic vld, input logic [DATA_W-1:0] dat, input logic rdy, input logic fl);
        bit do_push;
        bit do_pop;
        in_valid  = vld;
        in_data   = dat;
        out_ready = rdy;
        flush     = fl;
        @(posedge clk);
        do_push = vld && (mq.size() < DEPTH);
        do_pop  = rdy && (mq.size() > 0);
        if (fl) begin
            mq.delete();
        end else begin
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back(dat);
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        mq.delete();
        #12;
        tests_run++; if (count !== 0) begin tests_failed++; $display("FAIL reset_count got %0d exp 0", count); end
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
        tests_run++; if (out_data !== '0) begin tests_failed++; $display("FAIL reset_out_data got %0h exp 0", out_data); end
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got %0b exp 1", in_ready); end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_fill_drain();
        logic [DATA_W-1:0] vals [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
        for (int i = 0; i < 4; i++) tick(1'b1, vals[i], 1'b0, 1'b0);
        tests_run++; if (count !== 4) begin tests_failed++; $display("FAIL fill_count got %0d exp 4", count); end
        tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL fill_in_ready got %0b exp 0", in_ready); end
        tick(1'b1, 32'h55, 1'b0, 1'b0);
        tests_run++; if (count !== 4) begin tests_failed++; $display("FAIL refuse5_count got %0d exp 4", count); end
        tests_run++; if (out_data !== 32'h11) begin tests_failed++; $display("FAIL refuse5_head got %0h exp 11", out_data); end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== vals[i]) begin
                tests_failed++; $display("FAIL drain_%0d got v=%0b d=%0h exp v=1 d=%0h", i, out_valid, out_data, vals[i]);
            end
            tick(1'b0, '0, 1'b1, 1'b0);
        end
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL drain_empty_valid got %0b exp 0", out_valid); end
        tests_run++; if (out_data !== '0) begin tests_failed++; $display("FAIL drain_empty_data got %0h exp 0", out_data); end
    endtask

    task automatic test_streaming();
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, DATA_W'(32'hA0 + i), 1'b1, 1'b0);
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== DATA_W'(32'hA0 + i)) begin
                tests_failed++; $display("FAIL stream_data_%0d got v=%0b d=%0h exp v=1 d=%0h", i, out_valid, out_data, 32'hA0 + i);
            end
            tests_run++;
            if (count !== 1 || in_ready !== 1'b1) begin
                tests_failed++; $display("FAIL stream_occ_%0d got count=%0d rdy=%0b exp count=1 rdy=1", i, count, in_ready);
            end
        end
        tick(1'b0, '0, 1'b1, 1'b0);
        tests_run++; if (count !== 0) begin tests_failed++; $display("FAIL stream_drain got %0d exp 0", count); end
    endtask

    task automatic test_wrap();
        logic [DATA_W-1:0] sent [10];
        for (int i = 0; i < 10; i++) begin
            sent[i] = $urandom;
            tick(1'b1, sent[i], 1'b0, 1'b0);
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== sent[i]) begin
                tests_failed++; $display("FAIL wrap_%0d got v=%0b d=%0h exp v=1 d=%0h", i, out_valid, out_data, sent[i]);
            end
            tick(1'b0, '0, 1'b1, 1'b0);
        end
        tests_run++; if (count !== 0) begin tests_failed++; $display("FAIL wrap_end_count got %0d exp 0", count); end
    endtask

    task automatic test_full_pop();
        for (int i = 0; i < 4; i++) tick(1'b1, DATA_W'(32'hC0 + i), 1'b0, 1'b0);
        tests_run++; if (count !== 4) begin tests_failed++; $display("FAIL fullpop_pre got %0d exp 4", count); end
        tick(1'b1, 32'h99, 1'b1, 1'b0);
        tests_run++; if (count !== 3) begin tests_failed++; $display("FAIL fullpop_count got %0d exp 3", count); end
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL fullpop_in_ready got %0b exp 1", in_ready); end
        tests_run++; if (out_data !== 32'hC1) begin tests_failed++; $display("FAIL fullpop_head got %0h exp c1", out_data); end
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (out_data !== DATA_W'(32'hC1 + i)) begin
                tests_failed++; $display("FAIL fullpop_drain_%0d got %0h exp %0h", i, out_data, 32'hC1 + i);
            end
            tick(1'b0, '0, 1'b1, 1'b0);
        end
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL fullpop_empty got %0b exp 0", out_valid); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) tick(1'b1, DATA_W'(32'hF0 + i), 1'b0, 1'b0);
        tests_run++; if (count !== 3) begin tests_failed++; $display("FAIL flush_pre got %0d exp 3", count); end
        tick(1'b1, 32'hDEAD, 1'b1, 1'b1);
        tests_run++; if (count !== 0) begin tests_failed++; $display("FAIL flush_count got %0d exp 0", count); end
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_valid got %0b exp 0", out_valid); end
        tests_run++; if (out_data !== '0) begin tests_failed++; $display("FAIL flush_data got %0h exp 0", out_data); end
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, '0, 1'b1, 1'b0);
            tests_run++;
            if (out_valid !== 1'b0 || out_data === 32'hDEAD) begin
                tests_failed++; $display("FAIL flush_ghost_%0d got v=%0b d=%0h exp v=0 d!=dead", i, out_valid, out_data);
            end
        end
    endtask

    task automatic test_async_reset();
        tick(1'b1, 32'h61, 1'b0, 1'b0);
        tick(1'b1, 32'h62, 1'b0, 1'b0);
        in_valid = 1'b0;
        tests_run++; if (count !== 2) begin tests_failed++; $display("FAIL arst_pre got %0d exp 2", count); end
        #2 reset = 1'b0;
        mq.delete();
        #1;
        tests_run++; if (count !== 0) begin tests_failed++; $display("FAIL arst_count got %0d exp 0", count); end
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL arst_valid got %0b exp 0", out_valid); end
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL arst_in_ready got %0b exp 1", in_ready); end
        tests_run++; if (out_data !== '0) begin tests_failed++; $display("FAIL arst_data got %0h exp 0", out_data); end
        #2 reset = 1'b1;
        tick(1'b1, 32'h77, 1'b0, 1'b0);
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 32'h77) begin
            tests_failed++; $display("FAIL arst_after got v=%0b d=%0h exp v=1 d=77", out_valid, out_data);
        end
        tick(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] exp_data;
        for (int i = 0; i < 400; i++) begin
            tick(($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 2) != 0), ($urandom_range(0, 40) == 0));
            exp_data = (mq.size() > 0) ? mq[0] : '0;
            tests_run++;
            if (count !== CNT_W'(mq.size()) || out_valid !== (mq.size() > 0) ||
                in_ready !== (mq.size() < DEPTH) || out_data !== exp_data) begin
                tests_failed++;
                $display("FAIL rand_%0d got cnt=%0d v=%0b r=%0b d=%0h exp cnt=%0d v=%0b r=%0b d=%0h",
                         i, count, out_valid, in_ready, out_data,
                         mq.size(), (mq.size() > 0), (mq.size() < DEPTH), exp_data);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_streaming();
        test_wrap();
        test_full_pop();
        test_flush();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
